butterfly_pipe_array: RTL and testbench
=======================================

Name: butterfly_pipe_array

Overview:
- Pipelined, parametrised array of NUM_BF radix-2 DIT butterflies. Each lane computes X = A + B·W and Y = A − B·W on signed fixed-point complex samples.
- Successor to the 8-lane, 16-bit combinational butterfly block. Adds:
  - configurable width and lane count;
  - a registered 3-stage pipeline with valid/ready backpressure;
  - per-beat divide-by-2 scaling;
  - saturation with a sticky overflow flag.
- Sits between the FFT sample memory and the stage controller.

Parameters:
- NUM_BF, 8, number of parallel butterfly lanes (≥1).
- DATA_W, 16, signed width of each real or imaginary data component.
- TW_W, 16, signed width of each twiddle component, format Q1.(TW_W−1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_a_re, in_a_im  in  NUM_BF*DATA_W each  operand A; lane k occupies bits [k*DATA_W +: DATA_W].
- in_b_re, in_b_im  in  NUM_BF*DATA_W each  operand B, same packing.
- tw_re, tw_im  in  NUM_BF*TW_W each  twiddle W per lane.
- scale_en  in  1  sampled with the beat; when 1, that beat's results are halved.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out_x_re, out_x_im, out_y_re, out_y_im  out  NUM_BF*DATA_W each  results X and Y per lane.
- ovf_sticky  out  1  set by any saturation event.
- ovf_clear  in  1  clears ovf_sticky.

Behaviour:
- Pipeline stages:
  - S1 registers the operands and scale_en.
  - S2 computes the complex product P = B·W at full precision: P_re = br·wr − bi·wi, P_im = br·wi + bi·wr, each DATA_W+TW_W+1 bits. It then rounds: add 2^(TW_W−2), arithmetic shift right by TW_W−1, keep DATA_W+1 bits. A, the rounded P and the scale bit are registered.
  - S3 forms X = A+P and Y = A−P in DATA_W+2 bits. If the beat's scale bit is set, each component becomes (v+1)>>>1. Each component is then saturated to the DATA_W signed range and registered onto the outputs.
- Latency: exactly 3 cycles from the accept edge to out_valid when no stall occurs. Throughput is 1 beat per cycle.
- Flow control: a single global advance = !out_valid | out_ready. in_ready = advance, combinational from out_valid and out_ready.
  - On a stall, every stage register holds and outputs stay stable.
  - Bubbles do not collapse; each stage valid bit shifts only on advance.
- Valid bits: the stage-k valid bit loads the previous stage's valid bit on advance. A beat is accepted only when in_valid & in_ready.
- Overflow: ovf_sticky sets in the cycle a valid S3 result saturates any component in any lane, and only when advance = 1.
  - Simultaneous ovf_clear and a new overflow event: set wins.
  - ovf_clear alone clears the flag on the next edge.
- Reset: synchronous. Clears all valid bits, ovf_sticky, and all data registers to 0.
  - Reset values: out_valid = 0, out_x_*/out_y_* = 0, ovf_sticky = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial output is produced.
- Twiddle W = −1.0 (0x8000 for TW_W=16) is legal. +1.0 is not representable; use 0x7FFF.
- Lanes are fully independent. Saturation in one lane does not alter other lanes.

Test Plan (DATA_W=16, TW_W=16, NUM_BF=8, all lanes driven identically unless stated):
- Basic, no scale: A=100+0j, B=200+0j, W=0x7FFF+0j, scale_en=0 → 3 cycles later out_valid=1, X=300+0j, Y=−100+0j.
- Scale and −j twiddle: A=100+0j, B=200+0j, W=0+0x8000j, scale_en=1 → P=0−200j, X=50−100j, Y=50+100j.
- Saturation: A=0x7FFF+0j, B=0x7FFF+0j, W=0x7FFF in lane 3 only, all other lanes zero → lane 3 X_re=0x7FFF, Y_re=1; ovf_sticky=1 and remains set until ovf_clear; all other lanes 0.
- Backpressure: stream 5 beats with scale_en=0 and A_re=1..5, all other operands 0; hold out_ready=0 for 4 cycles after the first out_valid → outputs held stable, in_ready=0 during the stall, all 5 beats emerge in order with X_re=1..5 and none lost or duplicated.
- Bubbles: assert in_valid on alternate cycles → out_valid pattern is the same alternation delayed by 3 cycles.
- Reset mid-flight: accept 2 beats, assert reset for 1 cycle → out_valid never rises for those beats, ovf_sticky=0, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/butterfly_pipe_array.sv
// rtl/butterfly_pipe_array.sv - pipelined array of radix-2 DIT butterflies with scaling and saturation
module butterfly_pipe_array #(
  parameter int NUM_BF = 8,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_BF*DATA_W-1:0] in_a_re,
  input  logic [NUM_BF*DATA_W-1:0] in_a_im,
  input  logic [NUM_BF*DATA_W-1:0] in_b_re,
  input  logic [NUM_BF*DATA_W-1:0] in_b_im,
  input  logic [NUM_BF*TW_W-1:0]   tw_re,
  input  logic [NUM_BF*TW_W-1:0]   tw_im,
  input  logic                     scale_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_BF*DATA_W-1:0] out_x_re,
  output logic [NUM_BF*DATA_W-1:0] out_x_im,
  output logic [NUM_BF*DATA_W-1:0] out_y_re,
  output logic [NUM_BF*DATA_W-1:0] out_y_im,
  output logic                     ovf_sticky,
  input  logic                     ovf_clear
);

  localparam int PW  = DATA_W + TW_W + 1;
  localparam int RW  = DATA_W + 1;
  localparam int SW  = DATA_W + 2;
  localparam int VW  = NUM_BF * DATA_W;
  localparam int TVW = NUM_BF * TW_W;
  localparam int PVW = NUM_BF * RW;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);

  logic           advance;
  logic           s1_valid, s2_valid;
  logic           s1_scale, s2_scale;
  logic [VW-1:0]  s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic [TVW-1:0] s1_w_re, s1_w_im;
  logic [VW-1:0]  s2_a_re, s2_a_im;
  logic [PVW-1:0] s2_p_re, s2_p_im;
  logic [PVW-1:0] p_re_d, p_im_d;
  logic [VW-1:0]  x_re_d, x_im_d, y_re_d, y_im_d;
  logic [NUM_BF-1:0] lane_ovf;
  logic           ovf_set;

  // One global advance: every stage moves together or everything holds.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign ovf_set  = advance && s2_valid && (|lane_ovf);

  function automatic logic signed [SW-1:0] scale_half(input logic signed [SW-1:0] v,
                                                      input logic en);
    if (en)
      return (v + SW'(1)) >>> 1;
    else
      return v;
  endfunction

  // Returns {overflow, clamped value}; in range when all bits above the sign agree.
  function automatic logic [DATA_W:0] saturate(input logic signed [SW-1:0] v);
    if (v[SW-1:DATA_W-1] == {(SW-DATA_W+1){v[SW-1]}})
      return {1'b0, v[DATA_W-1:0]};
    else if (v[SW-1])
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  for (genvar k = 0; k < NUM_BF; k++) begin : g_lane
    logic signed [PW-1:0] br, bi, wr, wi;
    logic signed [PW-1:0] prod_re, prod_im;
    logic signed [SW-1:0] ar, ai, pr, pi;
    logic [DATA_W:0]      sat_xr, sat_xi, sat_yr, sat_yi;

    assign br = PW'($signed(s1_b_re[k*DATA_W +: DATA_W]));
    assign bi = PW'($signed(s1_b_im[k*DATA_W +: DATA_W]));
    assign wr = PW'($signed(s1_w_re[k*TW_W +: TW_W]));
    assign wi = PW'($signed(s1_w_im[k*TW_W +: TW_W]));

    assign prod_re = br * wr - bi * wi;
    assign prod_im = br * wi + bi * wr;

    // Round half up back to data scale, keeping one guard bit for W = -1.0.
    assign p_re_d[k*RW +: RW] = RW'((prod_re + RND) >>> (TW_W - 1));
    assign p_im_d[k*RW +: RW] = RW'((prod_im + RND) >>> (TW_W - 1));

    assign ar = SW'($signed(s2_a_re[k*DATA_W +: DATA_W]));
    assign ai = SW'($signed(s2_a_im[k*DATA_W +: DATA_W]));
    assign pr = SW'($signed(s2_p_re[k*RW +: RW]));
    assign pi = SW'($signed(s2_p_im[k*RW +: RW]));

    assign sat_xr = saturate(scale_half(ar + pr, s2_scale));
    assign sat_xi = saturate(scale_half(ai + pi, s2_scale));
    assign sat_yr = saturate(scale_half(ar - pr, s2_scale));
    assign sat_yi = saturate(scale_half(ai - pi, s2_scale));

    assign x_re_d[k*DATA_W +: DATA_W] = sat_xr[DATA_W-1:0];
    assign x_im_d[k*DATA_W +: DATA_W] = sat_xi[DATA_W-1:0];
    assign y_re_d[k*DATA_W +: DATA_W] = sat_yr[DATA_W-1:0];
    assign y_im_d[k*DATA_W +: DATA_W] = sat_yi[DATA_W-1:0];
    assign lane_ovf[k] = sat_xr[DATA_W] | sat_xi[DATA_W] | sat_yr[DATA_W] | sat_yi[DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_scale  <= 1'b0;
      s1_a_re   <= '0;
      s1_a_im   <= '0;
      s1_b_re   <= '0;
      s1_b_im   <= '0;
      s1_w_re   <= '0;
      s1_w_im   <= '0;
      s2_valid  <= 1'b0;
      s2_scale  <= 1'b0;
      s2_a_re   <= '0;
      s2_a_im   <= '0;
      s2_p_re   <= '0;
      s2_p_im   <= '0;
      out_valid <= 1'b0;
      out_x_re  <= '0;
      out_x_im  <= '0;
      out_y_re  <= '0;
      out_y_im  <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_scale  <= scale_en;
      s1_a_re   <= in_a_re;
      s1_a_im   <= in_a_im;
      s1_b_re   <= in_b_re;
      s1_b_im   <= in_b_im;
      s1_w_re   <= tw_re;
      s1_w_im   <= tw_im;
      s2_valid  <= s1_valid;
      s2_scale  <= s1_scale;
      s2_a_re   <= s1_a_re;
      s2_a_im   <= s1_a_im;
      s2_p_re   <= p_re_d;
      s2_p_im   <= p_im_d;
      out_valid <= s2_valid;
      out_x_re  <= x_re_d;
      out_x_im  <= x_im_d;
      out_y_re  <= y_re_d;
      out_y_im  <= y_im_d;
    end
  end

  // A new overflow event takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      ovf_sticky <= 1'b0;
    else if (ovf_set)
      ovf_sticky <= 1'b1;
    else if (ovf_clear)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_pipe_array.sv
// tb/tb_butterfly_pipe_array.sv - self-checking bench for butterfly_pipe_array
module tb_butterfly_pipe_array;
  localparam int NB = 8;
  localparam int DW = 16;
  localparam int VW = NB * DW;

  logic          tb_clk = 1'b0;
  logic          reset, in_valid, in_ready, scale_en, out_valid, out_ready;
  logic          ovf_sticky, ovf_clear;
  logic [VW-1:0] in_a_re, in_a_im, in_b_re, in_b_im, tw_re, tw_im;
  logic [VW-1:0] out_x_re, out_x_im, out_y_re, out_y_im;

  always #5 tb_clk = ~tb_clk;

  butterfly_pipe_array #(.NUM_BF(NB), .DATA_W(DW), .TW_W(16)) dut (
    .clk(tb_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .tw_re(tw_re), .tw_im(tw_im), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  typedef struct {
    logic [VW-1:0] xr, xi, yr, yi;
    bit            sat;
    bit            timed;
    int            acc;
  } beat_t;

  beat_t mq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    emitted = 0;
  bit    model_ovf = 0;
  bit    clr_next[int];
  bit    stall_free = 1;
  bit    head_seen = 0;
  bit    last_acc = 0;
  bit    obs[12];

  always @(negedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint v, input longint d);
    longint q;
    q = v / d;
    if ((v % d != 0) && (v < 0))
      q = q - 1;
    return q;
  endfunction

  function automatic longint wrap17(input longint v);
    if (v > 65535)  return v - 131072;
    if (v < -65536) return v + 131072;
    return v;
  endfunction

  // Reference butterfly: exact complex product, round half up to Q0, add/subtract,
  // optional halving with rounding, clamp to 16-bit signed.
  function automatic void bf_lane(input int ar, input int ai, input int br, input int bi,
                                  input int wr, input int wi, input bit sc,
                                  output int xr, output int xi, output int yr, output int yi,
                                  output bit ov);
    longint pr, pi;
    longint v[4];
    pr = wrap17(fdiv(longint'(br) * wr - longint'(bi) * wi + 16384, 32768));
    pi = wrap17(fdiv(longint'(br) * wi + longint'(bi) * wr + 16384, 32768));
    v[0] = ar + pr;
    v[1] = ai + pi;
    v[2] = ar - pr;
    v[3] = ai - pi;
    ov = 0;
    for (int i = 0; i < 4; i++) begin
      if (sc) v[i] = fdiv(v[i] + 1, 2);
      if (v[i] > 32767) begin v[i] = 32767; ov = 1; end
      else if (v[i] < -32768) begin v[i] = -32768; ov = 1; end
    end
    xr = int'(v[0]);
    xi = int'(v[1]);
    yr = int'(v[2]);
    yi = int'(v[3]);
  endfunction

  function automatic int lane(input logic [VW-1:0] v, input int k);
    return int'($signed(v[k*DW +: DW]));
  endfunction

  function automatic beat_t model_beat();
    beat_t b;
    int xr, xi, yr, yi;
    bit ov;
    b.sat = 0;
    b.timed = 0;
    b.acc = 0;
    for (int k = 0; k < NB; k++) begin
      bf_lane(lane(in_a_re, k), lane(in_a_im, k), lane(in_b_re, k), lane(in_b_im, k),
              lane(tw_re, k), lane(tw_im, k), scale_en, xr, xi, yr, yi, ov);
      b.xr[k*DW +: DW] = xr[DW-1:0];
      b.xi[k*DW +: DW] = xi[DW-1:0];
      b.yr[k*DW +: DW] = yr[DW-1:0];
      b.yi[k*DW +: DW] = yi[DW-1:0];
      b.sat = b.sat | ov;
    end
    return b;
  endfunction

  task automatic set_lane(input int k, input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi);
    in_a_re[k*DW +: DW] = 16'(ar);
    in_a_im[k*DW +: DW] = 16'(ai);
    in_b_re[k*DW +: DW] = 16'(br);
    in_b_im[k*DW +: DW] = 16'(bi);
    tw_re[k*DW +: DW]   = 16'(wr);
    tw_im[k*DW +: DW]   = 16'(wi);
  endtask

  task automatic set_all(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi);
    for (int k = 0; k < NB; k++) set_lane(k, ar, ai, br, bi, wr, wi);
  endtask

  task automatic clear_ops();
    set_all(0, 0, 0, 0, 0, 0);
  endtask

  // Inputs are set at negedge+1; the handshake is recorded at negedge+2.
  task automatic step();
    beat_t b;
    #1;
    last_acc = 0;
    if (reset) begin
      mq.delete();
      clr_next[cyc+1] = 1;
    end else begin
      if (ovf_clear) clr_next[cyc+1] = 1;
      if (in_valid && in_ready) begin
        b = model_beat();
        b.timed = stall_free;
        b.acc = cyc;
        mq.push_back(b);
        last_acc = 1;
      end
    end
    @(negedge tb_clk);
    #1;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) check(name, out_valid, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      step();
      n++;
    end
    check(name, mq.size(), 0);
  endtask

  always @(negedge tb_clk) begin
    #3;
    if (reset) begin
      head_seen = 0;
    end else begin
      if (clr_next.exists(cyc)) begin
        model_ovf = 0;
        clr_next.delete(cyc);
      end
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (mq.size() == 0) begin
        check("idle_out_valid", out_valid, 0);
      end else begin
        if (mq[0].timed && !head_seen && (cyc - mq[0].acc == 3))
          check("latency_valid", out_valid, 1);
        if (out_valid) begin
          if (mq[0].timed && !head_seen) check("latency", cyc - mq[0].acc, 3);
          head_seen = 1;
          if (mq[0].sat) model_ovf = 1;
          check_vec("x_re", out_x_re, mq[0].xr);
          check_vec("x_im", out_x_im, mq[0].xi);
          check_vec("y_re", out_y_re, mq[0].yr);
          check_vec("y_im", out_y_im, mq[0].yi);
          if (out_ready) begin
            void'(mq.pop_front());
            head_seen = 0;
            emitted++;
          end
        end
      end
      check("ovf_sticky", ovf_sticky, model_ovf);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int xr, xi, yr, yi, e0, sent, stall_left, n_stall;
    bit ov, started;

    bf_lane(100, 0, 200, 0, 32767, 0, 0, xr, xi, yr, yi, ov);
    check("pin_basic_xr", xr, 300);
    check("pin_basic_yr", yr, -100);
    bf_lane(100, 0, 200, 0, 0, -32768, 1, xr, xi, yr, yi, ov);
    check("pin_scale_xi", xi, -100);
    check("pin_scale_yi", yi, 100);
    bf_lane(32767, 0, 32767, 0, 32767, 0, 0, xr, xi, yr, yi, ov);
    check("pin_sat_yr", yr, 1);
    check("pin_sat_ov", ov, 1);
    bf_lane(-32768, 0, -32768, 0, -32768, 0, 0, xr, xi, yr, yi, ov);
    check("pin_negsat_yr", yr, -32768);
    check("pin_negsat_xr", xr, 0);

    reset = 1; in_valid = 0; out_ready = 1; scale_en = 0; ovf_clear = 0;
    clear_ops();
    @(negedge tb_clk);
    #1;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check_vec("rst_out_x_re", out_x_re, '0);
    check_vec("rst_out_y_im", out_y_im, '0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 0;
    step();

    // Basic beat, no scaling
    set_all(100, 0, 200, 0, 32767, 0);
    scale_en = 0; in_valid = 1;
    step();
    in_valid = 0;
    wait_out("basic_timeout");
    check("basic_x_re0", lane(out_x_re, 0), 300);
    check("basic_x_im7", lane(out_x_im, 7), 0);
    check("basic_y_re7", lane(out_y_re, 7), -100);
    step();

    // Scaled beat with W = -j
    set_all(100, 0, 200, 0, 0, -32768);
    scale_en = 1; in_valid = 1;
    step();
    in_valid = 0; scale_en = 0;
    wait_out("scale_timeout");
    check("scale_x_re", lane(out_x_re, 2), 50);
    check("scale_x_im", lane(out_x_im, 2), -100);
    check("scale_y_re", lane(out_y_re, 5), 50);
    check("scale_y_im", lane(out_y_im, 5), 100);
    step();

    // Saturation in lane 3 only
    clear_ops();
    set_lane(3, 32767, 0, 32767, 0, 32767, 0);
    in_valid = 1;
    step();
    in_valid = 0;
    wait_out("sat_timeout");
    check("sat_x_re3", lane(out_x_re, 3), 32767);
    check("sat_y_re3", lane(out_y_re, 3), 1);
    check("sat_x_re2", lane(out_x_re, 2), 0);
    check("sat_y_re4", lane(out_y_re, 4), 0);
    check("sat_ovf_set", ovf_sticky, 1);
    repeat (4) step();
    check("sat_ovf_hold", ovf_sticky, 1);
    ovf_clear = 1;
    step();
    ovf_clear = 0;
    check("sat_ovf_cleared", ovf_sticky, 0);

    // Set beats clear when both happen together
    ovf_clear = 1;
    in_valid = 1;
    step();
    in_valid = 0;
    wait_out("setwin_timeout");
    check("setwin_ovf", ovf_sticky, 1);
    step();
    check("setwin_then_clear", ovf_sticky, 0);
    ovf_clear = 0;
    clear_ops();

    // Back-to-back beats with distinct per-lane values, extremes and negative saturation
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < NB; k++)
        set_lane(k, k*4000 - 16000 + j*97, 9000 - k*2500 - j*31,
                 ((k % 2) ? -1 : 1) * (k*3000 + j*500), 20000 - k*5000,
                 -32768 + k*8000 + j, 30000 - k*8000 + j);
      if (j == 5) set_lane(0, -32768, 0, -32768, 0, -32768, 0);
      scale_en = j[0];
      in_valid = 1;
      step();
    end
    in_valid = 0; scale_en = 0;
    drain("mixed_drain");
    ovf_clear = 1;
    step();
    ovf_clear = 0;

    // Bubbles: valid on alternate cycles
    clear_ops();
    obs[0] = out_valid;
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 8) && (i % 2 == 0);
      set_all(10 + i, -i, 3*i + 1, 7, 12000 - 1000*i, -5000 + 700*i);
      scale_en = (i % 3 == 0);
      step();
      obs[i+1] = out_valid;
    end
    in_valid = 0; scale_en = 0;
    for (int j = 0; j < 12; j++)
      check($sformatf("bubble_valid_%0d", j), obs[j], (j == 3 || j == 5 || j == 7 || j == 9));
    drain("bubble_drain");

    // Backpressure: stall output for 4 cycles after the first out_valid
    clear_ops();
    stall_free = 0;
    e0 = emitted; sent = 0; started = 0; stall_left = 0; n_stall = 0;
    for (int t = 0; t < 60 && (sent < 5 || mq.size() > 0); t++) begin
      if (!started && out_valid) begin started = 1; stall_left = 4; end
      out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        stall_left--;
        if (out_valid) n_stall++;
      end
      in_valid = (sent < 5);
      clear_ops();
      if (sent < 5) set_all(sent + 1, 0, 0, 0, 0, 0);
      step();
      if (last_acc) sent++;
    end
    in_valid = 0; out_ready = 1; stall_free = 1;
    check("bp_sent", sent, 5);
    check("bp_emitted", emitted - e0, 5);
    check("bp_stall_cycles", n_stall, 4);
    check("bp_queue_empty", mq.size(), 0);

    // Reset mid-flight, with the sticky flag set beforehand
    clear_ops();
    set_lane(6, 32767, 0, 32767, 0, 32767, 0);
    in_valid = 1;
    step();
    in_valid = 0;
    wait_out("pre_rst_timeout");
    step();
    check("pre_rst_ovf", ovf_sticky, 1);
    set_all(5, 5, 5, 5, 1000, 1000);
    in_valid = 1;
    step();
    step();
    in_valid = 0;
    reset = 1;
    step();
    reset = 0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_ovf", ovf_sticky, 0);
    check("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("midrst_no_out_%0d", i), out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
